// File: rtl/crc_lfsr_param.sv
// Bit-serial CRC engine for CAN / CAN FD with frame sequencing and receive-side CRC field check.
// Width, polynomial, init value and stuff-bit handling are set by parameters.
module crc_lfsr_param #(
  parameter int                 CRC_W        = 15,
  parameter logic [CRC_W-1:0]   POLY         = 15'h4599,
  parameter logic [CRC_W-1:0]   INIT         = 15'h0000,
  parameter bit                 STUFF_IN_CRC = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof,
  input  logic             din,
  input  logic             din_valid,
  input  logic             stuff_bit,
  input  logic             data_end,
  input  logic             abort,
  output logic [CRC_W-1:0] crc,
  output logic             busy,
  output logic             crc_valid,
  output logic             crc_ok,
  output logic             crc_err
);

  localparam int CNT_W = $clog2(CRC_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [CRC_W-1:0]   crc_r, crc_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               mismatch_r, mismatch_s;
  logic               busy_r, valid_r, ok_r, err_r;
  logic               accept_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic [CRC_W-1:0]   field_shift_s;

  function automatic logic [CRC_W-1:0] lfsr_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = b ^ c[CRC_W-1];
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
  endfunction

  assign accept_s      = din_valid && (STUFF_IN_CRC || !stuff_bit);
  assign cnt_inc_s     = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  // Shifting the frozen CRC left by the count puts the expected field bit at the MSB.
  assign field_shift_s = crc_r << cnt_r;

  // Next-state, next-CRC and check-counter logic with abort > sof > data_end > bit priority.
  always_comb begin
    state_s    = state_r;
    crc_s      = crc_r;
    cnt_s      = cnt_r;
    mismatch_s = mismatch_r;
    if (abort) begin
      state_s = S_IDLE;
    end else if (sof) begin
      state_s    = S_CALC;
      crc_s      = accept_s ? lfsr_step(INIT, din) : INIT;
      cnt_s      = {CNT_W{1'b0}};
      mismatch_s = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_s = S_IDLE;
        end
        S_CALC: begin
          if (accept_s) begin
            crc_s = lfsr_step(crc_r, din);
          end else begin
            crc_s = crc_r;
          end
          if (data_end) begin
            state_s    = S_CHECK;
            cnt_s      = {CNT_W{1'b0}};
            mismatch_s = 1'b0;
          end else begin
            state_s = S_CALC;
          end
        end
        S_CHECK: begin
          // Stuff bits never belong to the CRC field, whatever the CRC coverage policy.
          if (din_valid && !stuff_bit) begin
            if (din != field_shift_s[CRC_W-1]) begin
              mismatch_s = 1'b1;
            end else begin
              mismatch_s = mismatch_r;
            end
            cnt_s = cnt_inc_s;
            if (cnt_inc_s == CNT_W'(CRC_W)) begin
              state_s = S_DONE;
            end else begin
              state_s = S_CHECK;
            end
          end else begin
            state_s = S_CHECK;
          end
        end
        S_DONE: begin
          state_s = S_DONE;
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // State, CRC and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      crc_r      <= {CRC_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      mismatch_r <= 1'b0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      ok_r       <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      crc_r      <= crc_s;
      cnt_r      <= cnt_s;
      mismatch_r <= mismatch_s;
      busy_r     <= (state_s == S_CALC) || (state_s == S_CHECK);
      valid_r    <= (state_s == S_DONE);
      ok_r       <= (state_s == S_DONE) && !mismatch_s;
      err_r      <= (state_s == S_DONE) && mismatch_s;
    end
  end

  assign crc       = crc_r;
  assign busy      = busy_r;
  assign crc_valid = valid_r;
  assign crc_ok    = ok_r;
  assign crc_err   = err_r;

endmodule

// File: tb/tb_crc_lfsr_param.sv
// Directed bench for crc_lfsr_param: CRC-15 (stuff excluded/included) and CRC-17 instances share stimulus;
// receive-check verdicts go through a scoreboard queue popped by a monitor on crc_valid.
module tb_crc_lfsr_param;

  logic clk = 1'b0;
  logic rst_n, sof, din, din_valid, stuff_bit, data_end, abort;

  logic [14:0] c15, c15s;
  logic [16:0] c17;
  logic b15, v15, ok15, er15;
  logic b15s, v15s, ok15s, er15s;
  logic b17, v17, ok17, er17;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  crc_lfsr_param #(.CRC_W(15), .POLY(15'h4599), .INIT(15'h0000), .STUFF_IN_CRC(1'b0)) u15 (
    .clk(clk), .rst_n(rst_n), .sof(sof), .din(din), .din_valid(din_valid), .stuff_bit(stuff_bit),
    .data_end(data_end), .abort(abort), .crc(c15), .busy(b15), .crc_valid(v15), .crc_ok(ok15), .crc_err(er15));

  crc_lfsr_param #(.CRC_W(15), .POLY(15'h4599), .INIT(15'h0000), .STUFF_IN_CRC(1'b1)) u15s (
    .clk(clk), .rst_n(rst_n), .sof(sof), .din(din), .din_valid(din_valid), .stuff_bit(stuff_bit),
    .data_end(data_end), .abort(abort), .crc(c15s), .busy(b15s), .crc_valid(v15s), .crc_ok(ok15s), .crc_err(er15s));

  crc_lfsr_param #(.CRC_W(17), .POLY(17'h1685B), .INIT(17'h10000), .STUFF_IN_CRC(1'b1)) u17 (
    .clk(clk), .rst_n(rst_n), .sof(sof), .din(din), .din_valid(din_valid), .stuff_bit(stuff_bit),
    .data_end(data_end), .abort(abort), .crc(c17), .busy(b17), .crc_valid(v17), .crc_ok(ok17), .crc_err(er17));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; all controls return low after the edge.
  task automatic cyc(input logic s, input logic d, input logic dv, input logic st,
                     input logic de, input logic ab);
    sof = s; din = d; din_valid = dv; stuff_bit = st; data_end = de; abort = ab;
    @(posedge clk);
    #1;
    sof = 1'b0; din = 1'b0; din_valid = 1'b0; stuff_bit = 1'b0; data_end = 1'b0; abort = 1'b0;
  endtask

  task automatic feed_field(input logic [14:0] f);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, f[14-i], 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 4) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: on each crc_valid rise, pop the expected {ok, err} and compare.
  always @(negedge clk) begin
    if (rst_n && v15 && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_verdict", 32'd1, 32'd0);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        chk("verdict_ok_err", {30'd0, ok15, er15}, {30'd0, e});
      end
    end
    prev_valid = v15;
  end

  initial begin
    rst_n = 1'b0; sof = 1'b0; din = 1'b0; din_valid = 1'b0;
    stuff_bit = 1'b0; data_end = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_crc15", 32'(c15), 32'h0);
    chk("rst_crc17", 32'(c17), 32'h0);
    chk("rst_flags15", {28'd0, b15, v15, ok15, er15}, 32'h0);
    chk("rst_flags15s", {28'd0, b15s, v15s, ok15s, er15s}, 32'h0);
    chk("rst_flags17", {28'd0, b17, v17, ok17, er17}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SOF bit 1, then data_end alone
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sof_step_crc", 32'(c15), 32'h4599);
    chk("sof_busy", 32'(b15), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("data_end_crc", 32'(c15), 32'h4599);
    chk("check_busy", 32'(b15), 32'h1);
    // Wrong field bit sets mismatch, then SOF without a valid bit reloads INIT
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sof_in_check_crc", 32'(c15), 32'h0);
    chk("sof_in_check_busy", 32'(b15), 32'h1);

    // Frame 1, stuff bit between, data_end with the last bit
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("calc_bit1", 32'(c15), 32'h4599);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("stuff_excluded", 32'(c15), 32'h4599);
    chk("stuff_included", 32'(c15s), 32'h4EAB);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("frame_crc", 32'(c15), 32'h4EAB);
    chk("frame_crc_stuffed", 32'(c15s), 32'h58CF);

    // Good receive check (mismatch from before must have been cleared)
    exp_q.push_back(2'b10);
    feed_field(15'h4EAB);
    drain("good_verdict_timeout");
    chk("done_busy", 32'(b15), 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("done_hold", {29'd0, v15, ok15, er15}, 32'b110);

    // Bad receive check, field bit 7 flipped
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("frame2_crc", 32'(c15), 32'h4EAB);
    exp_q.push_back(2'b01);
    feed_field(15'h4E2B);
    drain("bad_verdict_timeout");

    // Abort from DONE, then abort mid-CALC
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort_done_flags", {28'd0, b15, v15, ok15, er15}, 32'h0);
    chk("abort_keeps_crc", 32'(c15), 32'h4EAB);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("abort_calc_flags", {28'd0, b15, v15, ok15, er15}, 32'h0);
    chk("abort_calc_crc", 32'(c15), 32'h4599);

    // data_end and valid bits in IDLE are ignored
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("idle_data_end_busy", 32'(b15), 32'h0);
    chk("idle_crc_hold", 32'(c15), 32'h4599);

    // FD CRC-17 frame, then reset mid-CHECK
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("fd_crc17", 32'(c17), 32'h1685B);
    chk("fd_busy", 32'(b17), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_crc17", 32'(c17), 32'h0);
    chk("async_rst_flags", {28'd0, b17, v17, ok17, er17}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("no_restart_without_sof", {27'd0, b15, c15 == 15'h0, b17, c17 == 17'h0, 1'b0}, 32'b01010);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_lfsr_param.md
Name: crc_lfsr_param

Overview:
- Parametrised bit-serial CRC engine for the CAN controller; successor to the fixed CRC-15 LFSR.
- Covers classic CAN (CRC-15) and CAN FD (CRC-17/CRC-21) through width, polynomial, init and stuff-bit-policy parameters.
- Sits between the bit de-stuffer and the frame FSM.
- Adds frame-level sequencing (SOF restart, data-end, abort) and a receive-check mode that compares the transmitted CRC field against the computed one.

Parameters:
- CRC_W, 15, CRC register width (15, 17 or 21).
- POLY, 15'h4599, generator polynomial without the implicit x^CRC_W term, CRC_W bits.
- INIT, 0, register value loaded at SOF, CRC_W bits (CAN FD: 1 << (CRC_W-1)).
- STUFF_IN_CRC, 0, 0 = stuff bits excluded from the CRC (classic CAN); 1 = stuff bits included (FD data phase).

Ports:
- clk  in  1  system clock; bit-time strobes are gated through din_valid.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- sof  in  1  one-cycle pulse marking the SOF bit; starts a new frame.
- din  in  1  serial bit, MSB-first.
- din_valid  in  1  din is a new bit this cycle.
- stuff_bit  in  1  qualifies din as a stuff bit; sampled only with din_valid.
- data_end  in  1  pulse marking the last CRC-covered bit; the next CRC_W valid non-stuff bits form the CRC field.
- abort  in  1  error frame or bus-off; returns the block to IDLE.
- crc  out  CRC_W  live LFSR register.
- busy  out  1  high in CALC or CHECK.
- crc_valid  out  1  high in DONE.
- crc_ok  out  1  high in DONE when the received CRC field matches.
- crc_err  out  1  high in DONE on any mismatch.

Behaviour:
- Reset: state is IDLE, crc = 0, and every output is 0 (crc_valid, crc_ok, crc_err, busy).
- LFSR step on an accepted bit: nxt = din ^ crc[CRC_W-1]; crc <= {crc[CRC_W-2:0], 1'b0} ^ (nxt ? POLY : 0). The update is registered, so crc reflects the bit one cycle after it is accepted.
- A bit is accepted when din_valid && (STUFF_IN_CRC || !stuff_bit).
- States:
  - IDLE: crc holds its value.
    - sof -> CALC, with crc loaded as INIT stepped by din if the SOF bit is accepted that cycle, otherwise crc = INIT.
    - data_end, din_valid and stuff_bit are ignored.
  - CALC: each accepted bit steps the LFSR.
    - data_end -> CHECK. A bit accepted in the same cycle is stepped first.
    - crc is then frozen; the check counter and the mismatch flag are cleared.
  - CHECK: each valid, non-stuff bit is compared against crc[CRC_W-1-cnt] and the count increments.
    - Stuff bits inside the CRC field are always skipped, independent of STUFF_IN_CRC.
    - A mismatch sets a sticky flag.
    - When the count reaches CRC_W -> DONE.
  - DONE:
    - crc_valid = 1, crc_ok = !mismatch, crc_err = mismatch; these hold until sof or abort.
    - Valid bits are ignored.
- busy = (state == CALC || state == CHECK).
- Priority, highest first: abort > sof > data_end > bit processing.
  - sof in any state restarts the frame immediately (CAN hard sync on a new SOF).
  - abort forces IDLE and clears crc_valid, crc_ok and crc_err; crc keeps its last value.
- The check counter is $clog2(CRC_W+1) bits wide and never wraps: the transition fires at CRC_W.
- A data_end pulse in CHECK or DONE is ignored.
- rst_n asserted mid-frame clears everything asynchronously; the block restarts only on the next sof.

Test Plan:
- CRC_W=15, POLY=15'h4599, INIT=0:
  - sof with din=1, then data_end -> crc=15'h4599, state CHECK.
  - sof with din=1, then din=0 with data_end -> crc=15'h4EAB.
- Stuff exclusion (STUFF_IN_CRC=0): sof with din=1, then din=0 with stuff_bit=1, then din=0 with data_end -> crc=15'h4EAB.
  - Same sequence with STUFF_IN_CRC=1 -> crc differs from 15'h4EAB.
- Receive check, good: after the 15'h4EAB frame, feed 100111010101011 MSB-first, with one stuff bit inserted after the fifth bit -> after the 15th non-stuff bit, crc_valid=1, crc_ok=1, crc_err=0.
  - Flip bit 7 of that field -> crc_ok=0, crc_err=1.
- FD width: CRC_W=17, POLY=17'h1685B, INIT=17'h10000; sof with din=0, then data_end -> crc=17'h1685B.
- Control edges:
  - abort mid-CALC -> busy=0 next cycle, no crc_valid.
  - sof during CHECK -> crc reloads to INIT, the mismatch flag clears, state CALC.
  - rst_n low mid-CHECK -> all outputs 0 immediately.
  - data_end in IDLE -> no state change.
